// File: rtl/multi_asset_order_engine.sv
`default_nettype none
// ============================================================================
// Module  : multi_asset_order_engine
// Brief   : Per-asset limit-trigger order generator with cooldown and FWFT
//           order queue. Optional net-position limiting: POSITION_LIMIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module multi_asset_order_engine #(
  parameter int NUM_ASSETS = 4,
  parameter int PRICE_W    = 32,
  parameter int QTY_W      = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AID_W      = $clog2(NUM_ASSETS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [AID_W+2:0]   cfg_addr,
  input  logic [31:0]        cfg_wdata,
  input  logic               md_valid,
  input  logic [AID_W-1:0]   md_asset,
  input  logic [PRICE_W-1:0] md_price,
  output logic               ord_valid,
  input  logic               ord_ready,
  output logic [AID_W-1:0]   ord_asset,
  output logic [PRICE_W-1:0] ord_price,
  output logic [QTY_W-1:0]   ord_qty,
  output logic               ord_side,
  output logic [7:0]         ord_reason,
  output logic               fifo_full,
  output logic [15:0]        drop_cnt
);
  localparam int               c_PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0] c_DEPTH      = (c_PTR_W+1)'(FIFO_DEPTH);
  localparam logic [31:0]      c_NUM_ASSETS = 32'(NUM_ASSETS);

  logic [PRICE_W-1:0] r_buy_limit  [NUM_ASSETS];
  logic [PRICE_W-1:0] r_sell_limit [NUM_ASSETS];
  logic [QTY_W-1:0]   r_buy_qty    [NUM_ASSETS];
  logic [QTY_W-1:0]   r_sell_qty   [NUM_ASSETS];
  logic               r_enable     [NUM_ASSETS];
  logic [7:0]         r_cool_cfg   [NUM_ASSETS];
  logic [7:0]         r_cool_cnt   [NUM_ASSETS];

  logic               r_s1_valid, r_s2_valid;
  logic [AID_W-1:0]   r_s1_asset, r_s2_asset;
  logic [PRICE_W-1:0] r_s1_price, r_s2_price;

  logic [AID_W-1:0]   r_mem_asset [FIFO_DEPTH];
  logic [PRICE_W-1:0] r_mem_price [FIFO_DEPTH];
  logic [QTY_W-1:0]   r_mem_qty   [FIFO_DEPTH];
  logic               r_mem_side  [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic [15:0]        r_drop_cnt;

  logic [AID_W-1:0]   w_cfg_asset;
  logic [2:0]         w_cfg_reg;
  logic               w_cfg_hit;
  logic               w_buy, w_sell, w_pos_ok, w_gen, w_pop, w_write, w_drop;
  logic [QTY_W-1:0]   w_qty;

  assign w_cfg_asset = cfg_addr[AID_W+2:3];
  assign w_cfg_reg   = cfg_addr[2:0];
  assign w_cfg_hit   = cfg_we && (32'(w_cfg_asset) < c_NUM_ASSETS);

`ifdef POSITION_LIMIT_EN
  logic signed [31:0] r_max_pos [NUM_ASSETS];
  logic signed [31:0] r_pos     [NUM_ASSETS];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ASSETS; i++) begin
        r_buy_limit[i]  <= '0;
        r_sell_limit[i] <= '1;
        r_buy_qty[i]    <= '0;
        r_sell_qty[i]   <= '0;
        r_enable[i]     <= 1'b0;
        r_cool_cfg[i]   <= '0;
`ifdef POSITION_LIMIT_EN
        r_max_pos[i]    <= '0;
`endif
      end
    end else if (w_cfg_hit) begin
      case (w_cfg_reg)
        3'd0: r_buy_limit[w_cfg_asset]  <= PRICE_W'(cfg_wdata);
        3'd1: r_sell_limit[w_cfg_asset] <= PRICE_W'(cfg_wdata);
        3'd2: r_buy_qty[w_cfg_asset]    <= QTY_W'(cfg_wdata);
        3'd3: r_sell_qty[w_cfg_asset]   <= QTY_W'(cfg_wdata);
        3'd4: begin
          r_enable[w_cfg_asset]   <= cfg_wdata[0];
          r_cool_cfg[w_cfg_asset] <= cfg_wdata[15:8];
        end
`ifdef POSITION_LIMIT_EN
        3'd5: r_max_pos[w_cfg_asset] <= cfg_wdata;
`endif
        default: ;
      endcase
    end
  end

  // Out-of-range asset ids are dropped here so later stages can index freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_asset <= '0;
      r_s1_price <= '0;
      r_s2_valid <= 1'b0;
      r_s2_asset <= '0;
      r_s2_price <= '0;
    end else begin
      r_s1_valid <= md_valid && (32'(md_asset) < c_NUM_ASSETS);
      r_s1_asset <= md_asset;
      r_s1_price <= md_price;
      r_s2_valid <= r_s1_valid;
      r_s2_asset <= r_s1_asset;
      r_s2_price <= r_s1_price;
    end
  end

  assign w_buy  = (r_s2_price <= r_buy_limit[r_s2_asset])  && (r_buy_qty[r_s2_asset]  != '0);
  assign w_sell = (r_s2_price >= r_sell_limit[r_s2_asset]) && (r_sell_qty[r_s2_asset] != '0);
  assign w_qty  = w_sell ? r_sell_qty[r_s2_asset] : r_buy_qty[r_s2_asset];

`ifdef POSITION_LIMIT_EN
  logic signed [31:0] w_qty_s;
  logic signed [32:0] w_new_pos, w_abs_pos;

  // 33-bit arithmetic keeps the magnitude test free of overflow.
  assign w_qty_s   = 32'(w_qty);
  assign w_new_pos = w_sell ? (33'(r_pos[r_s2_asset]) - 33'(w_qty_s))
                            : (33'(r_pos[r_s2_asset]) + 33'(w_qty_s));
  assign w_abs_pos = w_new_pos[32] ? -w_new_pos : w_new_pos;
  assign w_pos_ok  = (w_abs_pos <= 33'(r_max_pos[r_s2_asset]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ASSETS; i++) r_pos[i] <= '0;
    end else if (w_write) begin
      r_pos[r_s2_asset] <= w_new_pos[31:0];
    end
  end
`else
  assign w_pos_ok = 1'b1;
`endif

  assign w_gen   = r_s2_valid && r_enable[r_s2_asset] && (r_cool_cnt[r_s2_asset] == 8'd0)
                   && (w_buy ^ w_sell) && w_pos_ok;
  assign w_pop   = ord_valid && ord_ready;
  assign w_write = w_gen && (!fifo_full || w_pop);
  assign w_drop  = w_gen && fifo_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ASSETS; i++) r_cool_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ASSETS; i++) begin
        if (w_gen && (r_s2_asset == AID_W'(i))) r_cool_cnt[i] <= r_cool_cfg[i];
        else if (r_cool_cnt[i] != 8'd0)         r_cool_cnt[i] <= r_cool_cnt[i] - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem_asset[r_wr_ptr] <= r_s2_asset;
      r_mem_price[r_wr_ptr] <= r_s2_price;
      r_mem_qty[r_wr_ptr]   <= w_qty;
      r_mem_side[r_wr_ptr]  <= w_sell;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Head fields are masked while empty so reset and idle both present zeros.
  assign ord_valid  = (r_count != '0);
  assign fifo_full  = (r_count == c_DEPTH);
  assign drop_cnt   = r_drop_cnt;
  assign ord_asset  = ord_valid ? r_mem_asset[r_rd_ptr] : '0;
  assign ord_price  = ord_valid ? r_mem_price[r_rd_ptr] : '0;
  assign ord_qty    = ord_valid ? r_mem_qty[r_rd_ptr]   : '0;
  assign ord_side   = ord_valid && r_mem_side[r_rd_ptr];
  assign ord_reason = !ord_valid ? 8'h00 : (r_mem_side[r_rd_ptr] ? 8'h02 : 8'h01);

endmodule
`default_nettype wire
